kb_event_fifo: RTL

Multi-source keyboard event buffer that sits between the keyboard decoders (MEGA65 matrix scanner, PS/2 port, future sources) and the ZX-Uno register bus. It queues every `{scancode, extended, released}` event in a DEPTH-entry FIFO, arbitrating between up to four channels. The CPU reads the events through the SCANCODE and KBSTATUS registers. The single-entry latch it replaces dropped events whenever a second key arrived before the CPU read the first; this block does not.

---
 rtl/kb_event_fifo.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/kb_event_fifo.sv
// Keyboard event queue: per-channel hold registers, round-robin arbiter, DEPTH-entry FIFO, ZX-Uno register view.
// Latency: new_key at E0 -> hold at E0 -> FIFO at E1 -> registered outputs at E2; pop ends a SCANCODE read, next head one edge later.
// Backpressure: a full FIFO stalls the holds; an event arriving on a still-occupied hold is dropped and sets sticky OVF.
// Ports: clk/rst (async, active-high); new_key/scancode/extended/released per channel;
//        zxuno_addr/zxuno_regrd/zxuno_regwr/din register bus; scancode_dout/oe_scancode,
//        kbstatus_dout/oe_kbstatus read data and enables; fifo_count occupancy.
module kb_event_fifo #(
  parameter int         NCHAN         = 2,
  parameter int         DEPTH         = 16,
  parameter logic [7:0] SCANCODE_ADDR = 8'h04,
  parameter logic [7:0] KBSTATUS_ADDR = 8'h05
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCHAN-1:0]       new_key,
  input  logic [8*NCHAN-1:0]     scancode,
  input  logic [NCHAN-1:0]       extended,
  input  logic [NCHAN-1:0]       released,
  input  logic [7:0]             zxuno_addr,
  input  logic                   zxuno_regrd,
  input  logic                   zxuno_regwr,
  input  logic [7:0]             din,
  output logic [7:0]             scancode_dout,
  output logic                   oe_scancode,
  output logic [7:0]             kbstatus_dout,
  output logic                   oe_kbstatus,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Hold registers: {released, extended, scancode}
  logic [NCHAN-1:0] hold_vld;
  logic [9:0]       hold_dat [NCHAN];
  logic [1:0]       rr_ptr;          // last granted channel

  // FIFO storage, entries are {ch[1:0], released, extended, scancode[7:0]}
  logic [11:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             oe_scancode_q;

  logic             kbst_wr;
  logic             flush;
  logic             ovf_clr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             gnt_any;
  logic [1:0]       gnt_ch;
  logic [9:0]       gnt_dat;
  int               arb_dist;
  int               arb_best;
  logic [NCHAN-1:0] drain;
  logic [11:0]      head;
  logic             unused_din;

  assign oe_scancode = (zxuno_addr == SCANCODE_ADDR) && zxuno_regrd;
  assign oe_kbstatus = (zxuno_addr == KBSTATUS_ADDR) && zxuno_regrd;

  assign kbst_wr    = zxuno_regwr && (zxuno_addr == KBSTATUS_ADDR);
  assign flush      = kbst_wr && din[0];
  assign ovf_clr    = kbst_wr && din[4];
  assign unused_din = ^{din[7:5], din[3:1]};

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // Pop on the falling edge of a SCANCODE access, so a long read pops once.
  assign pop  = oe_scancode_q && !oe_scancode && !empty && !flush;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = gnt_any && (!full || pop) && !flush;

  // Round-robin: the channel with the smallest distance above rr_ptr wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_ch   = '0;
    gnt_dat  = '0;
    arb_best = NCHAN;
    arb_dist = 0;
    for (int c = 0; c < NCHAN; c++) begin
      arb_dist = (c + 2 * NCHAN - 1 - int'(rr_ptr)) % NCHAN;
      if (hold_vld[c] && (arb_dist < arb_best)) begin
        arb_best = arb_dist;
        gnt_any  = 1'b1;
        gnt_ch   = 2'(c);
        gnt_dat  = hold_dat[c];
      end
    end
  end

  always_comb begin
    drain = '0;
    for (int c = 0; c < NCHAN; c++) begin
      drain[c] = push && (gnt_ch == 2'(c));
    end
  end

  // Hold registers and sticky overflow; a new overflow wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld <= '0;
      ovf      <= 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        hold_dat[c] <= '0;
      end
    end else begin
      if (ovf_clr) begin
        ovf <= 1'b0;
      end
      for (int c = 0; c < NCHAN; c++) begin
        if (flush) begin
          hold_vld[c] <= 1'b0;
        end else if (new_key[c] && hold_vld[c] && !drain[c]) begin
          ovf <= 1'b1;
        end else if (new_key[c]) begin
          hold_vld[c] <= 1'b1;
          hold_dat[c] <= {released[c], extended[c], scancode[8*c +: 8]};
        end else if (drain[c]) begin
          hold_vld[c] <= 1'b0;
        end
      end
    end
  end

  // FIFO pointers, occupancy and arbiter pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      rr_ptr        <= '0;
      oe_scancode_q <= 1'b0;
    end else begin
      oe_scancode_q <= oe_scancode;
      if (push) begin
        rr_ptr <= gnt_ch;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          cnt <= cnt + 1'b1;
        end else if (pop && !push) begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {gnt_ch, gnt_dat};
    end
  end

  // Register view, refreshed every cycle from the head entry, count and OVF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scancode_dout <= 8'h00;
      kbstatus_dout <= 8'h00;
      fifo_count    <= '0;
    end else begin
      fifo_count <= cnt;
      if (empty) begin
        scancode_dout <= 8'h00;
        kbstatus_dout <= {full, 2'b00, ovf, 4'b0000};
      end else begin
        scancode_dout <= head[7:0];
        kbstatus_dout <= {full, head[11:10], ovf, 1'b0, head[9], head[8], 1'b1};
      end
    end
  end

endmodule
